// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT streaming front/back end.
// Holds the controller state encoding, complex sample packing and bit reversal.
package fft_pkg;

  localparam int unsigned FFT_DATA_WIDTH = 16;
  localparam int unsigned FFT_ADDR_WIDTH = 8;
  localparam int unsigned BITREV_MAX     = 16;
  // Output slots must cover the two-cycle RAM read round trip plus the
  // presented bin so a steady m_ready sustains one bin per cycle.
  localparam int unsigned SKID_DEPTH     = 3;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } fft_state_t;

  typedef struct packed {
    logic signed [FFT_DATA_WIDTH-1:0] im;
    logic signed [FFT_DATA_WIDTH-1:0] re;
  } cplx_t;

  function automatic cplx_t pack_cplx(input logic signed [FFT_DATA_WIDTH-1:0] re,
                                      input logic signed [FFT_DATA_WIDTH-1:0] im);
    cplx_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

  // Reverse the low 'width' bits of addr; bits above width come back zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] addr,
                                                   input int unsigned width);
    logic [BITREV_MAX-1:0] rev;
    rev = {<<{addr}};
    return rev >> (BITREV_MAX - width);
  endfunction

endpackage

// File: rtl/fft_stream_io_if.sv
// Input sample stream and output bin stream of fft_stream_io.
// 'slave' is the block's view, 'master' the surrounding producer/consumer.
interface fft_stream_io_if
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH
) ();

  logic                    s_valid;
  logic                    s_ready;
  logic [2*DATA_WIDTH-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [2*DATA_WIDTH-1:0] m_data;
  logic                    m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fft_skid_buf.sv
// Small valid/ready output buffer for RAM read data plus the last flag.
// The writer must only push when a slot is guaranteed (credit held upstream).
module fft_skid_buf
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 2*FFT_DATA_WIDTH + 1,
  parameter int unsigned DEPTH = SKID_DEPTH,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [LVL_W-1:0] count;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop       = out_valid & out_ready;
  assign out_valid = (count != '0);
  assign out_data  = mem[head];
  assign level     = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '{default: '0};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (in_valid) begin
        mem[tail] <= in_data;
        tail      <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      count <= count + LVL_W'(in_valid) - LVL_W'(pop);
    end
  end

endmodule

// File: rtl/fft_stream_io.sv
// Streaming front/back end for the in-place FFT working RAM: bit-reversed
// fill, hand-off to the engine, then natural-order drain with backpressure.
module fft_stream_io
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FFT_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_stream_io_if.slave          io,
  output logic                    ram_sel,
  output logic                    ram_wen,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic [2*DATA_WIDTH-1:0] ram_wdata,
  output logic                    ram_ren,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  input  logic [2*DATA_WIDTH-1:0] ram_rdata,
  output logic                    fft_start,
  input  logic                    fft_done,
  output logic                    busy
);

  localparam int unsigned N     = 2**ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned W     = 2*DATA_WIDTH;
  localparam int unsigned LVL_W = $clog2(SKID_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  fft_state_t      state;
  logic [CW-1:0]   k_cnt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   o_cnt;
  logic            fill_done;
  logic            s_ready_q;
  logic            ren_last;
  logic            pend;
  logic            pend_last;

  logic            accept;
  logic            sk_valid;
  logic [W-1:0]    sk_data;
  logic            sk_last;
  logic [LVL_W-1:0] sk_level;
  logic            pop;
  logic [LVL_W:0]  lvl_next;
  logic [LVL_W:0]  committed;
  logic            room;

  assign accept     = io.s_valid & s_ready_q;
  assign pop        = sk_valid & io.m_ready;
  assign io.s_ready = s_ready_q;
  assign io.m_valid = sk_valid;
  assign io.m_data  = sk_data;
  assign io.m_last  = sk_last;
  assign busy       = (state != ST_FILL);
  assign ram_sel    = (state == ST_RUN);

  // Slots already spoken for once this edge settles: buffered bins plus the
  // read currently on the RAM port; a new read may issue only if one is left.
  always_comb begin
    lvl_next  = {1'b0, sk_level} + (LVL_W+1)'(pend) - (LVL_W+1)'(pop);
    committed = lvl_next + (LVL_W+1)'(ram_ren);
    room      = (committed < (LVL_W+1)'(SKID_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FILL;
      k_cnt     <= '0;
      r_cnt     <= '0;
      o_cnt     <= '0;
      fill_done <= 1'b0;
      s_ready_q <= 1'b1;
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_ren   <= 1'b0;
      ram_raddr <= '0;
      fft_start <= 1'b0;
      ren_last  <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      ram_ren   <= 1'b0;
      fft_start <= 1'b0;
      pend      <= ram_ren;
      pend_last <= ren_last;
      unique case (state)
        ST_FILL: begin
          if (fill_done) begin
            ram_wen   <= 1'b0;
            fill_done <= 1'b0;
            fft_start <= 1'b1;
            state     <= ST_RUN;
          end else begin
            ram_wen <= accept;
            if (accept) begin
              ram_waddr <= ADDR_WIDTH'(bitrev(BITREV_MAX'(k_cnt[ADDR_WIDTH-1:0]), ADDR_WIDTH));
              ram_wdata <= io.s_data;
              k_cnt     <= k_cnt + CW'(1);
              if (k_cnt == LAST) begin
                s_ready_q <= 1'b0;
                fill_done <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (fft_done) begin
            state     <= ST_DRAIN;
            ram_ren   <= 1'b1;
            ram_raddr <= '0;
            ren_last  <= (r_cnt == LAST);
            r_cnt     <= CW'(1);
          end
        end
        ST_DRAIN: begin
          if ((r_cnt != CW'(N)) && room) begin
            ram_ren   <= 1'b1;
            ram_raddr <= r_cnt[ADDR_WIDTH-1:0];
            ren_last  <= (r_cnt == LAST);
            r_cnt     <= r_cnt + CW'(1);
          end
          if (pop) begin
            o_cnt <= o_cnt + CW'(1);
            if (o_cnt == LAST) begin
              state     <= ST_FILL;
              s_ready_q <= 1'b1;
              k_cnt     <= '0;
              r_cnt     <= '0;
              o_cnt     <= '0;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  fft_skid_buf #(
    .WIDTH (W + 1),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pend),
    .in_data   ({pend_last, ram_rdata}),
    .out_valid (sk_valid),
    .out_ready (io.m_ready),
    .out_data  ({sk_last, sk_data}),
    .level     (sk_level)
  );

endmodule
